// File: rtl/sum_loop_ctrl.sv
// sum_loop_ctrl: Moore controller that sequences the 8-bit register-file/adder
// datapath to compute 0+1+...+10 and latch the sum into the output register.
// Register map used by the sequence: R0 reads as 0, R1 = i, R2 = sum,
// R3 = constant 1. The register file has no reset, so every run re-initialises
// R1..R3 before entering the loop.
// Adds a start/busy/done handshake, a synchronous abort, and a watchdog that
// stops a run whose loop keeps going past MAX_ITER iterations.

module sum_loop_ctrl #(
    parameter int MAX_ITER = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       done_ack,
    input  logic       R1Le10,
    output logic       RFSrcMuxSel,
    output logic [2:0] RAddr1,
    output logic [2:0] RAddr2,
    output logic [2:0] WAddr,
    output logic       we,
    output logic       OutPortEn,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] iter_cnt
);

    // State encoding
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_INIT_ONE = 4'd1;
    localparam logic [3:0] S_INIT_I   = 4'd2;
    localparam logic [3:0] S_INIT_SUM = 4'd3;
    localparam logic [3:0] S_CHECK    = 4'd4;
    localparam logic [3:0] S_ADD      = 4'd5;
    localparam logic [3:0] S_INC      = 4'd6;
    localparam logic [3:0] S_OUT      = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;
    localparam logic [3:0] S_ERR      = 4'd9;

    // Register-file addresses of the loop variables
    localparam logic [2:0] R_ZERO = 3'd0;
    localparam logic [2:0] R_I    = 3'd1;
    localparam logic [2:0] R_SUM  = 3'd2;
    localparam logic [2:0] R_ONE  = 3'd3;

    // Watchdog limit in the counter's width
    localparam logic [7:0] ITER_LIMIT = 8'(MAX_ITER);
    localparam logic [7:0] ITER_SAT   = 8'hFF;

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic [7:0] iter_cnt_reg;
    logic [7:0] iter_cnt_next;
    logic       in_busy_state;

    // Busy covers every sequencing state; abort only acts while busy
    always_comb begin
        in_busy_state = 1'b0;
        case (state_reg)
            S_INIT_ONE, S_INIT_I, S_INIT_SUM,
            S_CHECK, S_ADD, S_INC, S_OUT: in_busy_state = 1'b1;
            default:                      in_busy_state = 1'b0;
        endcase
    end

    // Next-state and iteration-counter logic; abort overrides the transition
    // but not the action of the state being left (the INC count still lands)
    always_comb begin
        state_next    = state_reg;
        iter_cnt_next = iter_cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next    = S_INIT_ONE;
                    iter_cnt_next = 8'd0;
                end
            end
            S_INIT_ONE: state_next = S_INIT_I;
            S_INIT_I:   state_next = S_INIT_SUM;
            S_INIT_SUM: state_next = S_CHECK;
            S_CHECK: begin
                if (!R1Le10) begin
                    state_next = S_OUT;
                end else if (iter_cnt_reg == ITER_LIMIT) begin
                    state_next = S_ERR;
                end else begin
                    state_next = S_ADD;
                end
            end
            S_ADD: state_next = S_INC;
            S_INC: begin
                state_next = S_CHECK;
                if (iter_cnt_reg != ITER_SAT) begin
                    iter_cnt_next = iter_cnt_reg + 8'd1;
                end
            end
            S_OUT: state_next = S_DONE;
            S_DONE: begin
                if (done_ack) begin
                    state_next = S_IDLE;
                end else if (start) begin
                    state_next    = S_INIT_ONE;
                    iter_cnt_next = 8'd0;
                end
            end
            S_ERR: begin
                if (done_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (abort && in_busy_state) begin
            state_next = S_IDLE;
        end
    end

    // State and counter registers, asynchronously cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            iter_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            iter_cnt_reg <= iter_cnt_next;
        end
    end

    // Moore output decode: every control output depends on the state only
    always_comb begin
        RFSrcMuxSel = 1'b0;
        RAddr1      = R_ZERO;
        RAddr2      = R_ZERO;
        WAddr       = R_ZERO;
        we          = 1'b0;
        OutPortEn   = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        case (state_reg)
            S_INIT_ONE: begin
                RFSrcMuxSel = 1'b1;
                WAddr       = R_ONE;
                we          = 1'b1;
            end
            S_INIT_I: begin
                WAddr = R_I;
                we    = 1'b1;
            end
            S_INIT_SUM: begin
                WAddr = R_SUM;
                we    = 1'b1;
            end
            S_CHECK: begin
                RAddr1 = R_I;
            end
            S_ADD: begin
                RAddr1 = R_SUM;
                RAddr2 = R_I;
                WAddr  = R_SUM;
                we     = 1'b1;
            end
            S_INC: begin
                RAddr1 = R_I;
                RAddr2 = R_ONE;
                WAddr  = R_I;
                we     = 1'b1;
            end
            S_OUT: begin
                RAddr1    = R_SUM;
                OutPortEn = 1'b1;
            end
            S_DONE: done  = 1'b1;
            S_ERR:  error = 1'b1;
            default: begin
                RFSrcMuxSel = 1'b0;
            end
        endcase
    end

    assign busy     = in_busy_state;
    assign iter_cnt = iter_cnt_reg;

endmodule

// File: tb/tb_sum_loop_ctrl.sv
// tb_sum_loop_ctrl: drives sum_loop_ctrl against a small datapath model
// (register file + adder + output register) and checks every cycle against a
// timeline model: a run is a count of edges since start was accepted, and the
// expected controls, status, counter and output follow from that count.

module tb_sum_loop_ctrl;

    localparam int MAX_ITER = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       done_ack = 1'b0;
    logic       R1Le10;
    logic       RFSrcMuxSel;
    logic [2:0] RAddr1, RAddr2, WAddr;
    logic       we, OutPortEn, busy, done, error;
    logic [7:0] iter_cnt;

    int checks = 0;
    int errors = 0;

    sum_loop_ctrl #(.MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .done_ack(done_ack), .R1Le10(R1Le10), .RFSrcMuxSel(RFSrcMuxSel),
        .RAddr1(RAddr1), .RAddr2(RAddr2), .WAddr(WAddr), .we(we),
        .OutPortEn(OutPortEn), .busy(busy), .done(done), .error(error),
        .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- datapath model ----------------
    logic [7:0] rf [0:7];
    logic [7:0] rdata1, rdata2, wdata, outport;
    logic       stuck = 1'b0;

    assign rdata1 = (RAddr1 == 3'd0) ? 8'd0 : rf[RAddr1];
    assign rdata2 = (RAddr2 == 3'd0) ? 8'd0 : rf[RAddr2];
    assign wdata  = RFSrcMuxSel ? 8'd1 : 8'(rdata1 + rdata2);
    assign R1Le10 = stuck ? 1'b1 : (rdata1 <= 8'd10);

    always @(posedge clk) begin
        if (we) rf[WAddr] <= wdata;
    end

    always @(posedge clk or posedge reset) begin
        if (reset)          outport <= 8'd0;
        else if (OutPortEn) outport <= rdata1;
    end

    // ---------------- timeline model ----------------
    // mode: 0 idle, 1 running, 2 done, 3 error
    int         m_mode = 0;
    int         m_n = 0;
    bit         m_stuck = 1'b0;
    int         m_iter = 0;
    logic [7:0] m_out = 8'd0;

    function automatic int last_check(input bit s);
        return s ? 3 + 3 * MAX_ITER : 36;
    endfunction

    // 0..2 init steps, 3 check, 4 add, 5 inc, 6 output
    function automatic int phase_of(input int n, input bit s);
        if (n < 3) return n;
        if (n <= last_check(s)) return 3 + (n - 3) % 3;
        return 6;
    endfunction

    function automatic int iter_at(input int n);
        return (n < 3) ? 0 : (n - 3) / 3;
    endfunction

    function automatic logic [11:0] ctrl_of(input int ph);
        case (ph)
            0: return {1'b1, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0};
            1: return {1'b0, 3'd0, 3'd0, 3'd1, 1'b1, 1'b0};
            2: return {1'b0, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0};
            3: return {1'b0, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0};
            4: return {1'b0, 3'd2, 3'd1, 3'd2, 1'b1, 1'b0};
            5: return {1'b0, 3'd1, 3'd3, 3'd1, 1'b1, 1'b0};
            default: return {1'b0, 3'd2, 3'd0, 3'd0, 1'b0, 1'b1};
        endcase
    endfunction

    function automatic logic [7:0] sum_to_ten();
        int s = 0;
        for (int i = 0; i <= 10; i++) s += i;
        return 8'(s);
    endfunction

    // Model advances on the same edge as the DUT
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode <= 0;
            m_iter <= 0;
            m_out  <= 8'd0;
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_mode <= 1; m_n <= 0; m_iter <= 0; m_stuck <= stuck;
                end
                1: begin
                    if (abort) begin
                        m_mode <= 0;
                        m_iter <= iter_at(m_n) + ((phase_of(m_n, m_stuck) == 5) ? 1 : 0);
                    end else if (!m_stuck && m_n == 37) begin
                        m_mode <= 2; m_iter <= 11; m_out <= sum_to_ten();
                    end else if (m_stuck && m_n == last_check(1'b1)) begin
                        m_mode <= 3; m_iter <= MAX_ITER;
                    end else begin
                        m_n <= m_n + 1; m_iter <= iter_at(m_n + 1);
                    end
                end
                2: if (done_ack) m_mode <= 0;
                   else if (start) begin
                       m_mode <= 1; m_n <= 0; m_iter <= 0; m_stuck <= stuck;
                   end
                default: if (done_ack) m_mode <= 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge
    int en_cnt = 0;
    always @(negedge clk) begin
        logic [11:0] exp_ctrl;
        exp_ctrl = (m_mode == 1) ? ctrl_of(phase_of(m_n, m_stuck)) : 12'd0;
        check("ctrl", {20'd0, RFSrcMuxSel, RAddr1, RAddr2, WAddr, we, OutPortEn}, {20'd0, exp_ctrl});
        check("status", {29'd0, busy, done, error},
              {29'd0, m_mode == 1, m_mode == 2, m_mode == 3});
        check("iter_cnt", {24'd0, iter_cnt}, 32'(m_iter));
        check("outport", {24'd0, outport}, {24'd0, m_out});
        if (OutPortEn) en_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Starts a run; k counts edges after the accepting edge E0.
    // which: 0 stop on done, 1 stop on error; stop_at >= 0 stops at that edge
    task automatic run(input bit hold, input int which, input int stop_at, output int k);
        start = 1'b1;
        k = 0;
        forever begin
            tick();
            if (k == 0) begin
                check("busy_at_E0", {31'd0, busy}, 32'd1);
                if (!hold) start = 1'b0;
            end
            if (k == stop_at) break;
            if (which == 0 && done) break;
            if (which == 1 && error) break;
            k++;
            if (k > 200) begin
                check("run_timeout", 32'(k), 32'd0);
                break;
            end
        end
    endtask

    initial begin
        int k, j, en0;

        do_reset();
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_outport", {24'd0, outport}, 32'd0);

        // Single run from a one-cycle start pulse
        en0 = en_cnt;
        run(1'b0, 0, -1, k);
        $display("run1: done after %0d edges outport=%0d iter=%0d", k, outport, iter_cnt);
        check("run1_latency", 32'(k), 32'd38);
        check("run1_outport", {24'd0, outport}, 32'd55);
        check("run1_iter", {24'd0, iter_cnt}, 32'd11);
        tick();
        check("run1_en_pulses", 32'(en_cnt - en0), 32'd1);
        done_ack = 1'b1; tick(); done_ack = 1'b0;

        // start held through DONE: back-to-back run
        run(1'b1, 0, -1, k);
        check("run2_latency", 32'(k), 32'd38);
        en0 = en_cnt;
        tick();
        check("rerun_done_drop", {31'd0, done}, 32'd0);
        j = 1;
        while (!done && j < 200) begin tick(); j++; end
        $display("rerun: done again %0d edges after first done", j);
        check("rerun_latency", 32'(j), 32'd39);
        check("rerun_outport", {24'd0, outport}, 32'd55);
        check("rerun_en_pulses", 32'(en_cnt - en0), 32'd1);
        start = 1'b0;
        done_ack = 1'b1; tick(); done_ack = 1'b0;

        // Abort in the 5th INC state
        do_reset();
        run(1'b0, 0, 17, k);
        check("abort_in_inc_we", {31'd0, we}, 32'd1);
        check("abort_in_inc_iter", {24'd0, iter_cnt}, 32'd4);
        abort = 1'b1; tick(); abort = 1'b0;
        $display("abort: busy=%0d done=%0d outport=%0d", busy, done, outport);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_outport", {24'd0, outport}, 32'd0);
        run(1'b0, 0, -1, k);
        check("post_abort_latency", 32'(k), 32'd38);
        check("post_abort_outport", {24'd0, outport}, 32'd55);
        done_ack = 1'b1; tick(); done_ack = 1'b0;

        // Compare flag stuck high: watchdog trips
        do_reset();
        stuck = 1'b1;
        en0 = en_cnt;
        run(1'b0, 1, -1, k);
        $display("watchdog: error after %0d edges iter=%0d", k, iter_cnt);
        check("err_latency", 32'(k), 32'd52);
        check("err_iter", {24'd0, iter_cnt}, 32'd16);
        check("err_no_en", 32'(en_cnt - en0), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        check("err_ignores_start", {30'd0, error, busy}, 32'd2);
        done_ack = 1'b1; tick(); done_ack = 1'b0;
        check("err_ack", {30'd0, error, busy}, 32'd0);
        stuck = 1'b0;

        // Reset asserted mid-run while in ADD
        run(1'b0, 0, 4, k);
        check("in_add_raddr1", {29'd0, RAddr1}, 32'd2);
        reset = 1'b1;
        #1;
        $display("async reset: busy=%0d we=%0d raddr1=%0d", busy, we, RAddr1);
        check("async_reset_outs", {18'd0, busy, done, error, we, OutPortEn, RFSrcMuxSel, RAddr1, WAddr}, 32'd0);
        tick();
        reset = 1'b0;
        run(1'b0, 0, -1, k);
        check("post_reset_latency", 32'(k), 32'd38);
        check("post_reset_outport", {24'd0, outport}, 32'd55);

        // done_ack and start together in DONE: ack wins
        done_ack = 1'b1; start = 1'b1; tick();
        done_ack = 1'b0; start = 1'b0;
        check("ack_wins", {29'd0, busy, done, error}, 32'd0);
        run(1'b0, 0, -1, k);
        check("after_ack_latency", 32'(k), 32'd38);
        done_ack = 1'b1; tick(); done_ack = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
